dm_arbiter: RTL and testbench

//  Shares the single-port word data memory between two requesters: port 0
//  (pipeline MEM stage) and port 1 (loader/debug).

---
 rtl/dm_arbiter_if.sv | 56 +++++
 rtl/dm_arbiter.sv | 141 ++++++++++++++
 tb/tb_dm_arbiter.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/dm_arbiter_if.sv
// Bundle of requester, clear-control and memory-port signals around the
// data-memory arbiter. slave = arbiter side; master = requesters plus memory.
interface dm_arbiter_if #(
  parameter int AW = 10,
  parameter int DW = 32
);
  logic          clr_req;
  logic          clr_busy;

  logic          r0_req;
  logic          r0_we;
  logic [AW-1:0] r0_addr;
  logic [DW-1:0] r0_wdata;
  logic [31:0]   r0_pc;
  logic          r0_gnt;
  logic          r0_rvalid;
  logic [DW-1:0] r0_rdata;

  logic          r1_req;
  logic          r1_we;
  logic [AW-1:0] r1_addr;
  logic [DW-1:0] r1_wdata;
  logic [31:0]   r1_pc;
  logic          r1_gnt;
  logic          r1_rvalid;
  logic [DW-1:0] r1_rdata;

  logic          m_we;
  logic          m_re;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [31:0]   m_pc;
  logic [DW-1:0] m_rdata;

  modport slave (
    input  clr_req,
    output clr_busy,
    input  r0_req, r0_we, r0_addr, r0_wdata, r0_pc,
    output r0_gnt, r0_rvalid, r0_rdata,
    input  r1_req, r1_we, r1_addr, r1_wdata, r1_pc,
    output r1_gnt, r1_rvalid, r1_rdata,
    output m_we, m_re, m_addr, m_wdata, m_pc,
    input  m_rdata
  );

  modport master (
    output clr_req,
    input  clr_busy,
    output r0_req, r0_we, r0_addr, r0_wdata, r0_pc,
    input  r0_gnt, r0_rvalid, r0_rdata,
    output r1_req, r1_we, r1_addr, r1_wdata, r1_pc,
    input  r1_gnt, r1_rvalid, r1_rdata,
    input  m_we, m_re, m_addr, m_wdata, m_pc,
    output m_rdata
  );
endinterface

// File: rtl/dm_arbiter.sv
// Two-port round-robin arbiter for the single-port data memory, with a
// registered read return and a one-word-per-cycle hardware clear sweep.
module dm_arbiter #(
  parameter int AW    = 10,
  parameter int DW    = 32,
  parameter int DEPTH = 1024
) (
  input  logic         clk,
  input  logic         clr_n,
  dm_arbiter_if.slave  bus
);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_e;

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  state_e        state_q, state_d;
  logic          last_q, last_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          rvalid0_q, rvalid0_d;
  logic          rvalid1_q, rvalid1_d;
  logic [DW-1:0] rdata0_q, rdata0_d;
  logic [DW-1:0] rdata1_q, rdata1_d;

  logic          gnt0, gnt1;
  logic          m_we, m_re;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [31:0]   m_pc;

  // Arbitration, clear sweep sequencing and read-return next state
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    m_we    = 1'b0;
    m_re    = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    m_pc    = 32'h0000_0000;

    case (state_q)
      S_IDLE: begin
        // r0 wins unless r1 is also asking and r0 was the last one served
        if (clr_n && bus.r0_req && (!bus.r1_req || last_q)) begin
          gnt0 = 1'b1;
        end else if (clr_n && bus.r1_req) begin
          gnt1 = 1'b1;
        end else begin
          gnt0 = 1'b0;
          gnt1 = 1'b0;
        end

        if (gnt0) begin
          m_we    = bus.r0_we;
          m_re    = ~bus.r0_we;
          m_addr  = bus.r0_addr;
          m_wdata = bus.r0_wdata;
          m_pc    = bus.r0_pc;
          last_d  = 1'b0;
        end else if (gnt1) begin
          m_we    = bus.r1_we;
          m_re    = ~bus.r1_we;
          m_addr  = bus.r1_addr;
          m_wdata = bus.r1_wdata;
          m_pc    = bus.r1_pc;
          last_d  = 1'b1;
        end else begin
          last_d  = last_q;
        end

        cnt_d   = '0;
        state_d = bus.clr_req ? S_CLEAR : S_IDLE;
      end
      S_CLEAR: begin
        m_we   = clr_n;
        m_addr = cnt_q;
        if (cnt_q == LAST_ADDR) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d   = cnt_q + AW'(1);
          state_d = S_CLEAR;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase

    busy_d    = (state_d == S_CLEAR);
    rvalid0_d = gnt0 & ~bus.r0_we;
    rvalid1_d = gnt1 & ~bus.r1_we;
    rdata0_d  = rvalid0_d ? bus.m_rdata : rdata0_q;
    rdata1_d  = rvalid1_d ? bus.m_rdata : rdata1_q;
  end

  // State, sweep counter and read-return registers
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q   <= S_IDLE;
      last_q    <= 1'b1;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
    end
  end

  assign bus.clr_busy  = busy_q;
  assign bus.r0_gnt    = gnt0;
  assign bus.r1_gnt    = gnt1;
  assign bus.r0_rvalid = rvalid0_q;
  assign bus.r1_rvalid = rvalid1_q;
  assign bus.r0_rdata  = rdata0_q;
  assign bus.r1_rdata  = rdata1_q;
  assign bus.m_we      = m_we;
  assign bus.m_re      = m_re;
  assign bus.m_addr    = m_addr;
  assign bus.m_wdata   = m_wdata;
  assign bus.m_pc      = m_pc;

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter: handshake, round robin, conflicts, clear
// sweep and reset during a sweep, against a behavioural memory.
module tb_dm_arbiter;
  localparam int AW    = 10;
  localparam int DW    = 32;
  localparam int DEPTH = 1024;

  logic clk   = 1'b0;
  logic clr_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  dm_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  dm_arbiter #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus)
  );

  logic [DW-1:0] mem [DEPTH];
  logic          fill_en = 1'b0;

  always @(posedge clk) begin
    if (fill_en) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'hC000_0000 | 32'(i);
    end else if (bus.m_we) begin
      mem[bus.m_addr] <= bus.m_wdata;
    end
  end

  assign bus.m_rdata = mem[bus.m_addr];

  task automatic idle_inputs();
    bus.clr_req  = 1'b0;
    bus.r0_req   = 1'b0; bus.r0_we = 1'b0; bus.r0_addr = '0; bus.r0_wdata = '0; bus.r0_pc = '0;
    bus.r1_req   = 1'b0; bus.r1_we = 1'b0; bus.r1_addr = '0; bus.r1_wdata = '0; bus.r1_pc = '0;
  endtask

  task automatic fill_mem();
    @(negedge clk); fill_en = 1'b1;
    @(negedge clk); fill_en = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    clr_n = 1'b0;
    fill_mem();
    bus.r0_req = 1'b1;
    #1;
    total++; if (bus.r0_gnt !== 1'b0 || bus.r1_gnt !== 1'b0) begin bad++; $display("FAIL rst_gnt got=%b%b exp=00", bus.r0_gnt, bus.r1_gnt); end
    bus.r0_req = 1'b0;
    #1;
    total++; if (bus.clr_busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", bus.clr_busy); end
    total++; if (bus.r0_rvalid !== 1'b0 || bus.r1_rvalid !== 1'b0) begin bad++; $display("FAIL rst_rvalid got=%b%b exp=00", bus.r0_rvalid, bus.r1_rvalid); end
    total++; if (bus.r0_rdata !== 32'h0 || bus.r1_rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%h/%h exp=0", bus.r0_rdata, bus.r1_rdata); end
    total++; if (bus.m_we !== 1'b0 || bus.m_re !== 1'b0 || bus.m_addr !== 10'd0 || bus.m_wdata !== 32'h0 || bus.m_pc !== 32'h0) begin
      bad++; $display("FAIL rst_mport got we=%b re=%b addr=%h wd=%h pc=%h exp=all 0", bus.m_we, bus.m_re, bus.m_addr, bus.m_wdata, bus.m_pc);
    end
    @(negedge clk); clr_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); #1;
      total++; if (bus.m_we !== 1'b0 || bus.m_re !== 1'b0) begin bad++; $display("FAIL idle_mport cyc=%0d got we=%b re=%b exp=0 0", k, bus.m_we, bus.m_re); end
    end
  endtask

  task automatic test_write_read();
    @(negedge clk);
    bus.r0_req = 1'b1; bus.r0_we = 1'b1; bus.r0_addr = 10'd5; bus.r0_wdata = 32'hDEAD_BEEF; bus.r0_pc = 32'h0000_0100;
    #1;
    total++; if (bus.r0_gnt !== 1'b1 || bus.r1_gnt !== 1'b0) begin bad++; $display("FAIL wr_gnt got=%b%b exp=10", bus.r0_gnt, bus.r1_gnt); end
    total++; if (bus.m_we !== 1'b1 || bus.m_re !== 1'b0 || bus.m_addr !== 10'd5) begin bad++; $display("FAIL wr_mport got we=%b re=%b addr=%0d exp=1 0 5", bus.m_we, bus.m_re, bus.m_addr); end
    total++; if (bus.m_wdata !== 32'hDEAD_BEEF || bus.m_pc !== 32'h0000_0100) begin bad++; $display("FAIL wr_data got=%h pc=%h exp=deadbeef 100", bus.m_wdata, bus.m_pc); end
    @(negedge clk);
    bus.r0_we = 1'b0; bus.r0_pc = 32'h0000_0104;
    #1;
    total++; if (bus.r0_rvalid !== 1'b0) begin bad++; $display("FAIL wr_no_rvalid got=%b exp=0", bus.r0_rvalid); end
    total++; if (bus.r0_gnt !== 1'b1 || bus.m_re !== 1'b1 || bus.m_we !== 1'b0) begin bad++; $display("FAIL rd_mport got gnt=%b re=%b we=%b exp=1 1 0", bus.r0_gnt, bus.m_re, bus.m_we); end
    @(negedge clk);
    bus.r0_req = 1'b0;
    #1;
    total++; if (bus.r0_rvalid !== 1'b1 || bus.r0_rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL rd_return got v=%b d=%h exp=1 deadbeef", bus.r0_rvalid, bus.r0_rdata); end
    @(negedge clk); #1;
    total++; if (bus.r0_rvalid !== 1'b0 || bus.r0_rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL rd_hold got v=%b d=%h exp=0 deadbeef", bus.r0_rvalid, bus.r0_rdata); end
  endtask

  task automatic test_round_robin();
    @(negedge clk); clr_n = 1'b0; #1; clr_n = 1'b1;
    @(negedge clk);
    bus.r0_req = 1'b1; bus.r0_we = 1'b0; bus.r0_addr = 10'd1;
    bus.r1_req = 1'b1; bus.r1_we = 1'b0; bus.r1_addr = 10'd2;
    for (int k = 0; k < 4; k++) begin
      logic e0, e1, v0, v1;
      e0 = (k % 2 == 0); e1 = (k % 2 == 1);
      v0 = (k % 2 == 1); v1 = (k >= 2) && (k % 2 == 0);
      #1;
      total++; if (bus.r0_gnt !== e0 || bus.r1_gnt !== e1) begin bad++; $display("FAIL rr_gnt cyc=%0d got=%b%b exp=%b%b", k, bus.r0_gnt, bus.r1_gnt, e0, e1); end
      total++; if (bus.r0_rvalid !== v0 || bus.r1_rvalid !== v1) begin bad++; $display("FAIL rr_rvalid cyc=%0d got=%b%b exp=%b%b", k, bus.r0_rvalid, bus.r1_rvalid, v0, v1); end
      @(negedge clk);
    end
    bus.r0_req = 1'b0; bus.r1_req = 1'b0;
    #1;
    total++; if (bus.r1_rvalid !== 1'b1 || bus.r1_rdata !== 32'hC000_0002 || bus.r0_rdata !== 32'hC000_0001) begin
      bad++; $display("FAIL rr_rdata got v1=%b d1=%h d0=%h exp=1 c0000002 c0000001", bus.r1_rvalid, bus.r1_rdata, bus.r0_rdata);
    end
  endtask

  task automatic test_conflict();
    // last=1: r0 write goes first, r1 then reads the new value
    @(negedge clk);
    bus.r0_req = 1'b1; bus.r0_we = 1'b1; bus.r0_addr = 10'd7; bus.r0_wdata = 32'hA5A5_A5A5;
    bus.r1_req = 1'b1; bus.r1_we = 1'b0; bus.r1_addr = 10'd7;
    #1;
    total++; if (bus.r0_gnt !== 1'b1 || bus.r1_gnt !== 1'b0) begin bad++; $display("FAIL cf1_first got=%b%b exp=10", bus.r0_gnt, bus.r1_gnt); end
    @(negedge clk); bus.r0_req = 1'b0; #1;
    total++; if (bus.r1_gnt !== 1'b1 || bus.m_re !== 1'b1 || bus.m_addr !== 10'd7) begin bad++; $display("FAIL cf1_second got gnt=%b re=%b addr=%0d exp=1 1 7", bus.r1_gnt, bus.m_re, bus.m_addr); end
    @(negedge clk); bus.r1_req = 1'b0; #1;
    total++; if (bus.r1_rvalid !== 1'b1 || bus.r1_rdata !== 32'hA5A5_A5A5) begin bad++; $display("FAIL cf1_post_write got v=%b d=%h exp=1 a5a5a5a5", bus.r1_rvalid, bus.r1_rdata); end

    // r1 withdraws after losing one round and must never be served
    @(negedge clk);
    bus.r0_req = 1'b1; bus.r0_we = 1'b0; bus.r0_addr = 10'd7;
    bus.r1_req = 1'b1; bus.r1_we = 1'b0; bus.r1_addr = 10'd3;
    #1;
    total++; if (bus.r0_gnt !== 1'b1 || bus.r1_gnt !== 1'b0) begin bad++; $display("FAIL wd_first got=%b%b exp=10", bus.r0_gnt, bus.r1_gnt); end
    @(negedge clk); bus.r0_req = 1'b0; bus.r1_req = 1'b0; #1;
    total++; if (bus.r1_gnt !== 1'b0 || bus.m_re !== 1'b0 || bus.m_we !== 1'b0) begin bad++; $display("FAIL wd_withdrawn got gnt=%b re=%b we=%b exp=0 0 0", bus.r1_gnt, bus.m_re, bus.m_we); end
    total++; if (bus.r0_rvalid !== 1'b1 || bus.r0_rdata !== 32'hA5A5_A5A5) begin bad++; $display("FAIL wd_r0_read got v=%b d=%h exp=1 a5a5a5a5", bus.r0_rvalid, bus.r0_rdata); end
    @(negedge clk); #1;
    total++; if (bus.r1_rvalid !== 1'b0) begin bad++; $display("FAIL wd_no_rvalid got=%b exp=0", bus.r1_rvalid); end

    // last=0: r1 read goes first and sees the pre-write value
    @(negedge clk);
    bus.r0_req = 1'b1; bus.r0_we = 1'b1; bus.r0_addr = 10'd7; bus.r0_wdata = 32'h5A5A_5A5A;
    bus.r1_req = 1'b1; bus.r1_we = 1'b0; bus.r1_addr = 10'd7;
    #1;
    total++; if (bus.r0_gnt !== 1'b0 || bus.r1_gnt !== 1'b1) begin bad++; $display("FAIL cf2_first got=%b%b exp=01", bus.r0_gnt, bus.r1_gnt); end
    @(negedge clk); bus.r1_req = 1'b0; #1;
    total++; if (bus.r0_gnt !== 1'b1 || bus.m_we !== 1'b1) begin bad++; $display("FAIL cf2_second got gnt=%b we=%b exp=1 1", bus.r0_gnt, bus.m_we); end
    total++; if (bus.r1_rdata !== 32'hA5A5_A5A5) begin bad++; $display("FAIL cf2_pre_write got=%h exp=a5a5a5a5", bus.r1_rdata); end
    @(negedge clk); bus.r0_req = 1'b0; #1;
    total++; if (mem[7] !== 32'h5A5A_5A5A) begin bad++; $display("FAIL cf2_mem got=%h exp=5a5a5a5a", mem[7]); end
  endtask

  task automatic test_clear();
    int errs;
    int first_bad;
    errs = 0; first_bad = -1;
    idle_inputs();
    fill_mem();
    @(negedge clk); bus.clr_req = 1'b1; #1;
    total++; if (bus.clr_busy !== 1'b0) begin bad++; $display("FAIL clr_not_yet got=%b exp=0", bus.clr_busy); end
    @(negedge clk);
    bus.clr_req = 1'b0;
    bus.r0_req = 1'b1; bus.r0_we = 1'b0; bus.r0_addr = 10'd512;
    for (int k = 0; k < DEPTH; k++) begin
      #1;
      if (bus.clr_busy !== 1'b1 || bus.m_addr !== AW'(k) || bus.m_we !== 1'b1 || bus.m_re !== 1'b0 ||
          bus.m_wdata !== 32'h0 || bus.m_pc !== 32'h0 || bus.r0_gnt !== 1'b0 || bus.r1_gnt !== 1'b0) begin
        errs++;
        if (first_bad < 0) first_bad = k;
      end
      bus.clr_req = (k == 100);
      @(negedge clk);
    end
    bus.clr_req = 1'b0;
    total++; if (errs !== 0) begin bad++; $display("FAIL clr_sweep got bad_cycles=%0d first=%0d exp=0", errs, first_bad); end
    #1;
    total++; if (bus.clr_busy !== 1'b0) begin bad++; $display("FAIL clr_len got busy=%b after %0d cycles exp=0", bus.clr_busy, DEPTH); end
    total++; if (bus.r0_gnt !== 1'b1 || bus.m_addr !== 10'd512) begin bad++; $display("FAIL clr_pending got gnt=%b addr=%0d exp=1 512", bus.r0_gnt, bus.m_addr); end
    @(negedge clk); bus.r0_addr = 10'd0; #1;
    total++; if (bus.r0_rvalid !== 1'b1 || bus.r0_rdata !== 32'h0) begin bad++; $display("FAIL clr_rd512 got v=%b d=%h exp=1 0", bus.r0_rvalid, bus.r0_rdata); end
    @(negedge clk); bus.r0_addr = 10'd1023; #1;
    total++; if (bus.r0_rvalid !== 1'b1 || bus.r0_rdata !== 32'h0) begin bad++; $display("FAIL clr_rd0 got v=%b d=%h exp=1 0", bus.r0_rvalid, bus.r0_rdata); end
    @(negedge clk); bus.r0_req = 1'b0; #1;
    total++; if (bus.r0_rvalid !== 1'b1 || bus.r0_rdata !== 32'h0) begin bad++; $display("FAIL clr_rd1023 got v=%b d=%h exp=1 0", bus.r0_rvalid, bus.r0_rdata); end
  endtask

  task automatic test_reset_mid_sweep();
    int n;
    idle_inputs();
    fill_mem();
    @(negedge clk); bus.clr_req = 1'b1;
    @(negedge clk); bus.clr_req = 1'b0;
    repeat (300) @(negedge clk);
    #1;
    total++; if (bus.m_addr !== 10'd300 || bus.clr_busy !== 1'b1) begin bad++; $display("FAIL mid_pos got addr=%0d busy=%b exp=300 1", bus.m_addr, bus.clr_busy); end
    #1; clr_n = 1'b0; #1;
    total++; if (bus.clr_busy !== 1'b0 || bus.m_we !== 1'b0 || bus.m_addr !== 10'd0) begin bad++; $display("FAIL mid_abort got busy=%b we=%b addr=%0d exp=0 0 0", bus.clr_busy, bus.m_we, bus.m_addr); end
    @(negedge clk); clr_n = 1'b1;
    @(negedge clk); bus.r0_req = 1'b1; bus.r0_we = 1'b0; bus.r0_addr = 10'd299;
    @(negedge clk); bus.r0_addr = 10'd300; #1;
    total++; if (bus.r0_rdata !== 32'h0) begin bad++; $display("FAIL mid_rd299 got=%h exp=0", bus.r0_rdata); end
    @(negedge clk); bus.r0_req = 1'b0; #1;
    total++; if (bus.r0_rdata !== 32'hC000_012C) begin bad++; $display("FAIL mid_rd300 got=%h exp=c000012c", bus.r0_rdata); end
    @(negedge clk); bus.clr_req = 1'b1;
    @(negedge clk); bus.clr_req = 1'b0; #1;
    total++; if (bus.clr_busy !== 1'b1 || bus.m_addr !== 10'd0) begin bad++; $display("FAIL restart got busy=%b addr=%0d exp=1 0", bus.clr_busy, bus.m_addr); end
    n = 1;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk); #1;
      if (bus.clr_busy !== 1'b1) break;
      n++;
    end
    total++; if (n !== DEPTH) begin bad++; $display("FAIL restart_len got=%0d exp=%0d", n, DEPTH); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_round_robin();
    test_conflict();
    test_clear();
    test_reset_mid_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
